// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO write-side and read-side blocks.
// Both sides use these so that their pointer widths and Gray encodings always match.
package async_fifo_pkg;

  // A pointer carries one extra wrap bit above the memory address.
  function automatic int PTR_W(input int addr_w);
    return addr_w + 1;
  endfunction

  // Binary to reflected Gray code; callers narrow the result to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of width 'size' (size <= 32).
// The write side uses it to turn the synchronized read pointer into an occupancy.
module gray2bin #(
  parameter int size = 5
) (
  input  logic [size-1:0] gray,
  output logic [size-1:0] bin
);

  assign bin = size'(async_fifo_pkg::gray2bin(32'(gray)));

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer and full-flag logic for an asynchronous FIFO.
// Keeps the binary write pointer, publishes its Gray form to the read-domain
// synchronizer, and raises wfull against the synchronized Gray read pointer.
// Optional occupancy outputs (wlevel, walmost_full) are built only when the
// macro ASYNC_FIFO_LEVEL_EN is defined; otherwise those ports read as zero.
module wptr_full
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              werr,
  output logic [ADDR_W:0]   wlevel,
  output logic              walmost_full
);

  localparam int PW = PTR_W(ADDR_W);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic [PW-1:0] full_cmp;
  logic          wfull_q, wfull_d;
  logic          werr_q, werr_d;

  // A write only lands when there is room and we are not in reset.
  assign wen = winc & ~wfull_q & ~rst;

  // Next pointer, its Gray form, and the full/overflow decisions for this edge.
  always_comb begin
    wbin_d   = wbin_q + PW'(wen);
    wgray_d  = PW'(bin2gray(32'(wbin_d)));
    full_cmp = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    wfull_d  = (wgray_d == full_cmp);
    werr_d   = werr_q | (winc & wfull_q);
  end

  // Pointer, full and sticky-overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= wfull_d;
      werr_q  <= werr_d;
    end
  end

  assign waddr = wbin_q[ADDR_W-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;
  assign werr  = werr_q;

`ifdef ASYNC_FIFO_LEVEL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] wlevel_d, wlevel_q;
  logic          walmost_d, walmost_q;

  gray2bin #(
    .size(PW)
  ) u_gray2bin (
    .gray(wq2_rptr),
    .bin (rbin)
  );

  // Occupancy uses the post-write pointer and the current read pointer together.
  always_comb begin
    wlevel_d  = wbin_d - rbin;
    walmost_d = (int'(wlevel_d) >= AF_LEVEL);
  end

  // Occupancy and almost-full registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wlevel_q  <= '0;
      walmost_q <= 1'b0;
    end else begin
      wlevel_q  <= wlevel_d;
      walmost_q <= walmost_d;
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_q;
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule
